// File: rtl/slc3_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : slc3_button_conditioner (+ helper slc3_key_debounce)
// Purpose  : Input stage for the SLC-3 top. Synchronizes and debounces the
//            active-low Run/Continue keys (clean level + one-cycle press
//            pulse) and synchronizes the switch bank.
// Option   : SLC3_AUTO_REPEAT_EN - Continue key auto-repeats while held.
// Revision : 1.0 - initial release
// ============================================================================

// Per-key conditioner: 2-flop synchronizer followed by a debounce FSM.
module slc3_key_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 7
`ifdef SLC3_AUTO_REPEAT_EN
  ,
  parameter int REPEAT_CYCLES   = 64,
  parameter bit REPEAT_EN       = 1'b0
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic i_key_n,
  output logic o_pulse,
  output logic o_level
);

  typedef enum logic [1:0] {
    S_RELEASED    = 2'd0,
    S_PRESS_CHK   = 2'd1,
    S_HELD        = 2'd2,
    S_RELEASE_CHK = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_deb_last = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef SLC3_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] c_rpt_last = CNT_W'(REPEAT_CYCLES - 1);
`endif

  state_t           r_state;
  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pulse;
  logic             r_level;
`ifdef SLC3_AUTO_REPEAT_EN
  logic [CNT_W-1:0] r_rpt_cnt;
`endif

  // Synchronizer, debounce FSM and registered level/pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_state   <= S_RELEASED;
      r_cnt     <= '0;
      r_pulse   <= 1'b0;
      r_level   <= 1'b0;
`ifdef SLC3_AUTO_REPEAT_EN
      r_rpt_cnt <= '0;
`endif
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
      r_pulse <= 1'b0;
      case (r_state)
        S_RELEASED: begin
          r_level <= 1'b0;
          if (!r_sync2) begin
            r_state <= S_PRESS_CHK;
            r_cnt   <= '0;
          end
        end
        S_PRESS_CHK: begin
          if (r_sync2) begin
            // Too short: treat as a glitch.
            r_state <= S_RELEASED;
          end else if (r_cnt == c_deb_last) begin
            r_state   <= S_HELD;
            r_level   <= 1'b1;
            r_pulse   <= 1'b1;
`ifdef SLC3_AUTO_REPEAT_EN
            r_rpt_cnt <= '0;
`endif
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_HELD: begin
          r_level <= 1'b1;
          if (r_sync2) begin
            r_state <= S_RELEASE_CHK;
            r_cnt   <= '0;
          end
`ifdef SLC3_AUTO_REPEAT_EN
          else if (REPEAT_EN) begin
            if (r_rpt_cnt == c_rpt_last) begin
              r_pulse   <= 1'b1;
              r_rpt_cnt <= '0;
            end else begin
              r_rpt_cnt <= r_rpt_cnt + 1'b1;
            end
          end
`endif
        end
        S_RELEASE_CHK: begin
          // Repeat counter is held here so a bounce resumes the cadence.
          r_level <= 1'b1;
          if (!r_sync2) begin
            r_state <= S_HELD;
          end else if (r_cnt == c_deb_last) begin
            r_state   <= S_RELEASED;
            r_level   <= 1'b0;
`ifdef SLC3_AUTO_REPEAT_EN
            r_rpt_cnt <= '0;
`endif
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_RELEASED;
      endcase
    end
  end

  assign o_pulse = r_pulse;
  assign o_level = r_level;

endmodule

// Top: two independent key conditioners plus the switch synchronizer.
module slc3_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_CYCLES   = 64,
  parameter int SW_WIDTH        = 10
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Run_n,
  input  logic                Continue_n,
  input  logic [SW_WIDTH-1:0] SW,
  output logic                Run_pulse,
  output logic                Continue_pulse,
  output logic                Run_level,
  output logic                Continue_level,
  output logic [SW_WIDTH-1:0] SW_sync
);

  localparam int c_max_cycles = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES
                                                                  : REPEAT_CYCLES;
  localparam int c_cnt_w      = $clog2(c_max_cycles) + 1;

  logic [SW_WIDTH-1:0] r_sw_meta;
  logic [SW_WIDTH-1:0] r_sw_sync;

  // Switches are only synchronized; they are not debounced.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= SW;
      r_sw_sync <= r_sw_meta;
    end
  end

  assign SW_sync = r_sw_sync;

`ifdef SLC3_AUTO_REPEAT_EN
  slc3_key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (c_cnt_w),
    .REPEAT_CYCLES  (REPEAT_CYCLES),
    .REPEAT_EN      (1'b0)
  ) u_run (
    .clk    (Clk),
    .rst    (Reset),
    .i_key_n(Run_n),
    .o_pulse(Run_pulse),
    .o_level(Run_level)
  );

  slc3_key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (c_cnt_w),
    .REPEAT_CYCLES  (REPEAT_CYCLES),
    .REPEAT_EN      (1'b1)
  ) u_continue (
    .clk    (Clk),
    .rst    (Reset),
    .i_key_n(Continue_n),
    .o_pulse(Continue_pulse),
    .o_level(Continue_level)
  );
`else
  slc3_key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (c_cnt_w)
  ) u_run (
    .clk    (Clk),
    .rst    (Reset),
    .i_key_n(Run_n),
    .o_pulse(Run_pulse),
    .o_level(Run_level)
  );

  slc3_key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (c_cnt_w)
  ) u_continue (
    .clk    (Clk),
    .rst    (Reset),
    .i_key_n(Continue_n),
    .o_pulse(Continue_pulse),
    .o_level(Continue_level)
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_slc3_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_slc3_button_conditioner
// Purpose  : Directed self-checking bench for slc3_button_conditioner with
//            DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8. Edge indices below count
//            rising edges from the start of a window; edge 1 is the first
//            edge that samples the new input value.
// Revision : 1.0 - initial release
// ============================================================================
module tb_slc3_button_conditioner;

  localparam int DEB = 4;
  localparam int RPT = 8;
  localparam int SWW = 10;

  logic           Clk = 1'b0;
  logic           Reset;
  logic           Run_n;
  logic           Continue_n;
  logic [SWW-1:0] SW;
  logic           Run_pulse;
  logic           Continue_pulse;
  logic           Run_level;
  logic           Continue_level;
  logic [SWW-1:0] SW_sync;

  slc3_button_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_CYCLES  (RPT),
    .SW_WIDTH       (SWW)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Run_n         (Run_n),
    .Continue_n    (Continue_n),
    .SW            (SW),
    .Run_pulse     (Run_pulse),
    .Continue_pulse(Continue_pulse),
    .Run_level     (Run_level),
    .Continue_level(Continue_level),
    .SW_sync       (SW_sync)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  // Per-window observations.
  int edge_idx;
  int run_cnt, cont_cnt;
  int run_first, cont_first;
  int run_fall, cont_fall;
  int run_lo_seen, run_hi_seen;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clr();
    edge_idx    = 0;
    run_cnt     = 0;
    cont_cnt    = 0;
    run_first   = -1;
    cont_first  = -1;
    run_fall    = -1;
    cont_fall   = -1;
    run_lo_seen = 0;
    run_hi_seen = 0;
  endtask

  // Advance n rising edges, observing outputs on each following falling edge.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge Clk);
      edge_idx++;
      if (Run_pulse) begin
        run_cnt++;
        if (run_first < 0) run_first = edge_idx;
      end
      if (Continue_pulse) begin
        cont_cnt++;
        if (cont_first < 0) cont_first = edge_idx;
      end
      if (!Run_level && run_fall < 0) run_fall = edge_idx;
      if (!Continue_level && cont_fall < 0) cont_fall = edge_idx;
      if (Run_level) run_hi_seen = 1;
      else           run_lo_seen = 1;
    end
  endtask

  function automatic int outs();
    return int'({Run_pulse, Continue_pulse, Run_level, Continue_level, SW_sync});
  endfunction

  initial begin
    Reset      = 1'b1;
    Run_n      = 1'b0;
    Continue_n = 1'b1;
    SW         = 10'h3FF;
    @(negedge Clk);

    // 1: Run held through reset; all outputs stay 0 while Reset is high.
    clr();
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk($sformatf("reset_outs_%0d", k), outs(), 0);
    end
    Reset = 1'b0;
    clr();
    step(10);
    chk("t1_run_first", run_first, DEB + 3);
    chk("t1_run_cnt", run_cnt, 1);
    chk("t1_run_level", int'(Run_level), 1);
    chk("t1_cont_cnt", cont_cnt, 0);
    Run_n = 1'b1;
    clr();
    step(10);
    chk("t1_run_fall", run_fall, DEB + 3);
    chk("t1_rel_pulses", run_cnt, 0);

    // 2: Two-cycle press is rejected.
    clr();
    Run_n = 1'b0;
    step(2);
    Run_n = 1'b1;
    step(12);
    chk("t2_run_cnt", run_cnt, 0);
    chk("t2_run_hi_seen", run_hi_seen, 0);

    // 3: Continue held 20 cycles then released.
    clr();
    Continue_n = 1'b0;
    step(20);
    chk("t3_cont_first", cont_first, DEB + 3);
`ifdef SLC3_AUTO_REPEAT_EN
    chk("t3_cont_cnt", cont_cnt, 2);
`else
    chk("t3_cont_cnt", cont_cnt, 1);
`endif
    chk("t3_cont_level", int'(Continue_level), 1);
    chk("t3_run_cnt", run_cnt, 0);
    Continue_n = 1'b1;
    clr();
    step(10);
    chk("t3_cont_fall", cont_fall, DEB + 3);
    chk("t3_rel_pulses", cont_cnt, 0);

    // 4: One-cycle bounce while Run is held.
    clr();
    Run_n = 1'b0;
    step(12);
    chk("t4_first_pulse", run_cnt, 1);
    clr();
    Run_n = 1'b1;
    step(1);
    Run_n = 1'b0;
    step(12);
    chk("t4_bounce_pulses", run_cnt, 0);
    chk("t4_level_dropped", run_lo_seen, 0);
    Run_n = 1'b1;
    step(10);

    // 5: Simultaneous press of both keys.
    clr();
    Run_n      = 1'b0;
    Continue_n = 1'b0;
    step(10);
    chk("t5_run_first", run_first, DEB + 3);
    chk("t5_cont_first", cont_first, DEB + 3);
    chk("t5_run_cnt", run_cnt, 1);
    chk("t5_cont_cnt", cont_cnt, 1);
    Run_n      = 1'b1;
    Continue_n = 1'b1;
    step(10);

    // 6a: Switch bus synchronizer latency (previous value was 3FF).
    SW = 10'h006;
    step(1);
    chk("t6_sw_edge1", int'(SW_sync), 'h3FF);
    step(1);
    chk("t6_sw_edge2", int'(SW_sync), 'h006);

    // 6b: Reset mid-debounce discards the pending press.
    clr();
    Run_n = 1'b0;
    step(4);
    Reset = 1'b1;
    step(2);
    chk("t6_reset_outs", outs(), 0);
    Run_n = 1'b1;
    Reset = 1'b0;
    step(10);
    chk("t6_reset_run_cnt", run_cnt, 0);
    chk("t6_reset_level", run_hi_seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
